// File: rtl/sample_fifo.sv
// sample_fifo: single-clock synchronous FIFO buffering samples ahead of the
// FIR core. It provides an occupancy count, programmable almost-full and
// almost-empty thresholds, sticky overflow/underflow flags and a synchronous
// flush. The read side is either a registered read or first-word-fall-through.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = DEPTH - 1,
  parameter int AE_TH  = 1,
  parameter bit FWFT   = 1'b0,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags come from the registered count only, so accept decisions
  // always use last cycle's full/empty and a same-cycle read never makes
  // room for a write (or vice versa).
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_TH));
  assign almost_empty = (count <= CW'(AE_TH));

  assign wr_acc = wr_en & ~full  & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  // Storage write; memory is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of the queue is always visible; rd_en just pops it.
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      // Registered read: data loads on accept, valid pulses the cycle after.
      // A flush drops the pending pulse but keeps the last word on rd_data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (clr) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: doc/sample_fifo.md
# sample_fifo

Parametrised single-clock synchronous FIFO for the FIR sample path, replacing the fixed 4×16 dual-clock buffer. It buffers input samples ahead of the filter core and generalises data width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable standard or first-word-fall-through read mode. One clock domain only; no CDC inside the block.

## Interface
- DATA_W, 16, sample width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- AF_TH, DEPTH-1, almost_full asserted when count ≥ AF_TH (1..DEPTH)
- AE_TH, 1, almost_empty asserted when count ≤ AE_TH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- CW, derived as $clog2(DEPTH)+1; count width (localparam, not overridable)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; highest priority after reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data holds a newly read word (see Operation)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_TH
- almost_empty  out  1  count ≤ AE_TH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Both use the registered full/empty at the edge.
- wr_acc: mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH (natural wrap).
- rd_acc: rd_ptr increments modulo DEPTH.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Write while full is dropped with no pointer or memory change, and overflow is set. A simultaneous read does not make room in the same cycle.
- Read while empty changes nothing and sets underflow. A simultaneous write is not readable in the same cycle.
- Sticky flags stay set until clr or reset.
- clr: pointers and count go to 0, overflow and underflow are cleared, rd_valid goes to 0, rd_data holds its value. wr_en and rd_en are ignored that cycle. Memory contents are not cleared.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
- FWFT=0:
  - rd_data is a register loaded with mem[rd_ptr] on rd_acc.
  - rd_valid is a one-cycle pulse in the cycle after rd_acc.
  - rd_data holds its last value otherwise.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = ~empty. rd_en acts as a pop/acknowledge of the visible head.
- Reset (rst_n low, asynchronous):
  - Pointers and count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, rd_valid = 0, rd_data = 0 (FWFT=0).
  - Memory is not reset.
  - Reset asserted mid-transfer discards all contents immediately.

## Timing
- Write to count/flag update: 1 clock (visible after the accepting edge).
- FWFT=0 read latency: data and rd_valid appear 1 clock after the rd_en edge.
- FWFT=1:
  - A word written into an empty FIFO appears on rd_data, with rd_valid = 1, 1 clock after the write edge.
  - After rd_acc, the next word is visible 1 clock later.
- Sustained throughput: 1 write and 1 read per clock at any occupancy 1..DEPTH−1.
- Reset release: first write may be accepted on the first rising edge with rst_n high.

## Test plan
- DEPTH=4, FWFT=0: after reset write 0x1111, 0x2222, 0x3333, 0x4444 -> full=1, count=4, almost_full asserted from count 3. A 5th write (0x5555) is dropped and overflow=1. Four reads return 0x1111..0x4444, each with a rd_valid pulse 1 clock later. Then empty=1.
- Read from empty after reset -> underflow=1, count stays 0, no rd_valid pulse. clr -> underflow=0.
- Wrap-around: 10 write/read pairs in lockstep with an incrementing pattern 0x0000..0x0009 across a pointer wrap -> count constant, data in order, no flags.
- Simultaneous wr_en/rd_en at count=4 -> read accepted, write dropped, overflow=1, count=3. At count=0 -> write accepted, underflow=1, count=1.
- FWFT=1: write 0xABCD into an empty FIFO -> rd_data=0xABCD and rd_valid=1 on the next cycle. rd_en -> empty=1 next cycle.
- Assert rst_n low asynchronously between edges at count=3 -> count=0, empty=1, flags cleared immediately. Afterwards the first write after release is the first word read out.
